// File: rtl/vga_fb_scan_if.sv
// Framebuffer read port between the scan-out engine (master) and the pixel memory (slave).
interface vga_fb_scan_if #(
    parameter int ADDR_W = 17
);
    // rd_en is a valid-only qualifier for addr (there is no ready/backpressure);
    // the slave returns mem[addr] on data_in exactly MEM_LAT cycles after an addr with rd_en=1.
    logic [ADDR_W-1:0] addr;
    logic              rd_en;
    logic [11:0]       data_in;

    modport master (output addr, output rd_en, input data_in);
    modport slave  (input addr, input rd_en, output data_in);
endinterface

// File: rtl/vga_fb_scan.sv
// VGA scan-out: display timing, framebuffer addressing (1x/2x, mirror) and pipeline-aligned RGB/syncs.
// Define VGA_FB_TESTPAT_EN to replace data_in with an internal 8-bar colour pattern.
module vga_fb_scan #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_W     = 320,
    parameter int FB_H     = 240,
    parameter int ADDR_W   = 17,
    parameter int MEM_LAT  = 1
) (
    input  logic          clk_25mHz,
    input  logic          rst,
    input  logic [1:0]    mode,
    vga_fb_scan_if.master fb,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic [3:0]    vga_r,
    output logic [3:0]    vga_g,
    output logic [3:0]    vga_b,
    output logic          frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CW      = $clog2(FB_W + 1);
    localparam int PIPE_D  = MEM_LAT + 2;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_DISP_1X  = HW'(FB_W);
    localparam logic [HW-1:0] H_DISP_2X  = HW'(2 * FB_W);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_DISP_1X  = VW'(FB_H);
    localparam logic [VW-1:0] V_DISP_2X  = VW'(2 * FB_H);
    localparam logic [CW-1:0] COL_LAST   = CW'(FB_W - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [1:0]        mode_q;
    logic [CW-1:0]     col_cnt;
    logic              col_phase;
    logic [ADDR_W-1:0] row_base;
    logic              row_phase;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_en_q;

    logic              at_origin;
    logic              line_end;
    logic              frame_end;
    logic [1:0]        mode_eff;
    logic              scale2;
    logic              mirror;
    logic              h_in;
    logic              v_in;
    logic              region;
    logic [CW-1:0]     col_idx;
    logic              hs_raw;
    logic              vs_raw;

    // At the frame origin the incoming mode already governs the very first pixel.
    always_comb begin
        at_origin = (h_cnt == '0) && (v_cnt == '0);
        line_end  = (h_cnt == H_LAST);
        frame_end = line_end && (v_cnt == V_LAST);
        mode_eff  = at_origin ? mode : mode_q;
        scale2    = mode_eff[0];
        mirror    = mode_eff[1];
        h_in      = scale2 ? (h_cnt < H_DISP_2X) : (h_cnt < H_DISP_1X);
        v_in      = scale2 ? (v_cnt < V_DISP_2X) : (v_cnt < V_DISP_1X);
        region    = h_in && v_in;
        col_idx   = mirror ? (COL_LAST - col_cnt) : col_cnt;
        hs_raw    = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
        vs_raw    = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
    end

    always_ff @(posedge clk_25mHz or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_25mHz or posedge rst) begin
        if (rst) begin
            mode_q <= 2'b00;
        end else if (at_origin) begin
            mode_q <= mode;
        end
    end

    // Unmirrored column counter; in 2x mode col_phase holds each column for two pixels.
    always_ff @(posedge clk_25mHz or posedge rst) begin
        if (rst) begin
            col_cnt   <= '0;
            col_phase <= 1'b0;
        end else if (line_end) begin
            col_cnt   <= '0;
            col_phase <= 1'b0;
        end else if (region) begin
            if (!scale2) begin
                col_cnt <= col_cnt + 1'b1;
            end else begin
                col_phase <= ~col_phase;
                if (col_phase) begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end

    // Row base is accumulated by adding FB_W, so no multiplier is needed for addr.
    always_ff @(posedge clk_25mHz or posedge rst) begin
        if (rst) begin
            row_base  <= '0;
            row_phase <= 1'b0;
        end else if (frame_end) begin
            row_base  <= '0;
            row_phase <= 1'b0;
        end else if (line_end && v_in) begin
            if (!scale2) begin
                row_base <= row_base + ROW_STEP;
            end else begin
                row_phase <= ~row_phase;
                if (row_phase) begin
                    row_base <= row_base + ROW_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk_25mHz or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            rd_en_q <= 1'b0;
        end else begin
            rd_en_q <= region;
            if (region) begin
                addr_q <= row_base + ADDR_W'(col_idx);
            end else if (frame_end) begin
                addr_q <= '0;
            end
        end
    end

    assign fb.addr  = addr_q;
    assign fb.rd_en = rd_en_q;

    // Syncs and frame_start travel the full MEM_LAT+2 pipe; the region flag only needs to
    // reach the RGB register, one stage short of the pins.
    logic [PIPE_D-1:0]  hs_pipe;
    logic [PIPE_D-1:0]  vs_pipe;
    logic [PIPE_D-1:0]  fs_pipe;
    logic [MEM_LAT:0]   reg_pipe;

    always_ff @(posedge clk_25mHz or posedge rst) begin
        if (rst) begin
            hs_pipe  <= '1;
            vs_pipe  <= '1;
            fs_pipe  <= '0;
            reg_pipe <= '0;
        end else begin
            hs_pipe  <= {hs_pipe[PIPE_D-2:0], hs_raw};
            vs_pipe  <= {vs_pipe[PIPE_D-2:0], vs_raw};
            fs_pipe  <= {fs_pipe[PIPE_D-2:0], at_origin};
            reg_pipe <= {reg_pipe[MEM_LAT-1:0], region};
        end
    end

    assign vga_hs      = hs_pipe[PIPE_D-1];
    assign vga_vs      = vs_pipe[PIPE_D-1];
    assign frame_start = fs_pipe[PIPE_D-1];

    logic [11:0] pix_src;

`ifdef VGA_FB_TESTPAT_EN
    localparam int BAR_W = FB_W / 8;

    function automatic logic [11:0] bar_color(input logic [CW-1:0] c);
        logic [2:0]  idx;
        logic [11:0] rgb;
        idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (c >= CW'(k * BAR_W)) begin
                idx = idx + 3'd1;
            end
        end
        case (idx)
            3'd0:    rgb = 12'hFFF;
            3'd1:    rgb = 12'hFF0;
            3'd2:    rgb = 12'h0FF;
            3'd3:    rgb = 12'h0F0;
            3'd4:    rgb = 12'hF0F;
            3'd5:    rgb = 12'hF00;
            3'd6:    rgb = 12'h00F;
            default: rgb = 12'h000;
        endcase
        return rgb;
    endfunction

    // Bar colour is computed alongside addr and delayed to arrive when memory data would.
    logic [11:0] bar_pipe [0:MEM_LAT];

    always_ff @(posedge clk_25mHz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= MEM_LAT; i++) begin
                bar_pipe[i] <= '0;
            end
        end else begin
            bar_pipe[0] <= bar_color(col_idx);
            for (int i = 1; i <= MEM_LAT; i++) begin
                bar_pipe[i] <= bar_pipe[i-1];
            end
        end
    end

    assign pix_src = bar_pipe[MEM_LAT];
`else
    assign pix_src = fb.data_in;
`endif

    logic [11:0] rgb_q;

    always_ff @(posedge clk_25mHz or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= reg_pipe[MEM_LAT] ? pix_src : 12'h000;
        end
    end

    assign vga_r = rgb_q[11:8];
    assign vga_g = rgb_q[7:4];
    assign vga_b = rgb_q[3:0];
endmodule

// File: tb/tb_vga_fb_scan.sv
// Bench for vga_fb_scan on a reduced raster (56x31 total, 16x10 framebuffer) with a 1-cycle memory.
`timescale 1ns/1ps
module tb_vga_fb_scan;
    localparam int HA = 40, HFP = 4, HSY = 6, HBP = 6;
    localparam int VA = 24, VFP = 2, VSY = 2, VBP = 3;
    localparam int FBW = 16, FBH = 10, AW = 8, ML = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;

    logic       clk_25mHz = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       vga_hs, vga_vs, frame_start;
    logic [3:0] vga_r, vga_g, vga_b;

    vga_fb_scan_if #(.ADDR_W(AW)) fb ();

    vga_fb_scan #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .FB_W(FBW), .FB_H(FBH), .ADDR_W(AW), .MEM_LAT(ML)
    ) dut (
        .clk_25mHz(clk_25mHz),
        .rst(rst),
        .mode(mode),
        .fb(fb),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .frame_start(frame_start)
    );

    // ---------------- clock / reset-relative cycle count ----------------
    always #20 clk_25mHz = ~clk_25mHz;

    int ncyc = 0;
    always @(posedge clk_25mHz or posedge rst) begin
        if (rst) ncyc = 0;
        else     ncyc = ncyc + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, ncyc, act, exp);
        end
    endtask

    // ---------------- memory model: data = f(addr), one cycle later ----------------
    function automatic logic [11:0] pix_of(input logic [AW-1:0] a);
        return 12'hABC ^ {4'h0, a};
    endfunction

    logic [AW-1:0] mem_addr_prev = '0;
    initial fb.data_in = 12'h000;
    always @(negedge clk_25mHz) begin
        fb.data_in = pix_of(mem_addr_prev);
        mem_addr_prev = fb.addr;
    end

    // ---------------- behavioural model + scoreboard ----------------
    logic [AW:0]  exp_addr_q[$];   // {rd_en, addr}
    logic [14:0]  exp_pin_q[$];    // {frame_start, hs, vs, rgb}
    logic [1:0]   frame_mode = 2'b00;
    int           last_addr = 0;

    task automatic model_step(input int p);
        int h, v, s, col, row;
        logic region;
        logic [11:0] rgb;
        h = p % HT;
        v = (p / HT) % VT;
        if (h == 0 && v == 0) frame_mode = mode;
        s = frame_mode[0] ? 2 : 1;
        region = (h < s * FBW) && (v < s * FBH);
        col = h / s;
        if (frame_mode[1]) col = FBW - 1 - col;
        row = v / s;
        if (region) last_addr = row * FBW + col;
        else if (h == HT - 1 && v == VT - 1) last_addr = 0;
        rgb = region ? pix_of(AW'(last_addr)) : 12'h000;
        exp_addr_q.push_back({region, AW'(last_addr)});
        exp_pin_q.push_back({(h == 0 && v == 0),
                             !(h >= HA + HFP && h < HA + HFP + HSY),
                             !(v >= VA + VFP && v < VA + VFP + VSY),
                             rgb});
    endtask

    always @(negedge clk_25mHz) begin : compare
        logic [AW:0] ea;
        logic [14:0] ep;
        if (rst) begin
            exp_addr_q.delete();
            exp_pin_q.delete();
            exp_pin_q.push_back(15'h3000);
            exp_pin_q.push_back(15'h3000);
            frame_mode = 2'b00;
            last_addr = 0;
            model_step(0);
        end else begin
            ea = exp_addr_q.pop_front();
            ep = exp_pin_q.pop_front();
            chk("addr", fb.addr, ea[AW-1:0]);
            chk("rd_en", fb.rd_en, ea[AW]);
            chk("frame_start", frame_start, ep[14]);
            chk("vga_hs", vga_hs, ep[13]);
            chk("vga_vs", vga_vs, ep[12]);
            chk("rgb", {vga_r, vga_g, vga_b}, ep[11:0]);
            model_step(ncyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int k);
        int guard;
        guard = 0;
        if (ncyc > k) begin
            chk("wait_order", ncyc, k);
        end else begin
            while (ncyc != k && guard < k + 8) begin
                @(negedge clk_25mHz);
                guard = guard + 1;
            end
            if (ncyc != k) chk("wait_timeout", ncyc, k);
        end
        #1;
    endtask

    task automatic chk_addr_at(input int k, input int a, input logic rd);
        wait_cyc(k);
        chk("lit_addr", fb.addr, a);
        chk("lit_rd_en", fb.rd_en, rd);
    endtask

    initial begin
        repeat (2) @(negedge clk_25mHz);
        #1 rst = 1'b0;

        // frame 1, mode 00
        chk_addr_at(1, 0, 1'b1);
        wait_cyc(2);  chk("lit_rgb_pre", {vga_r, vga_g, vga_b}, 12'h000);
        wait_cyc(3);
        chk("lit_r", vga_r, 4'hA);
        chk("lit_g", vga_g, 4'hB);
        chk("lit_b", vga_b, 4'hC);
        chk("lit_fs_on", frame_start, 1'b1);
        wait_cyc(4);  chk("lit_fs_off", frame_start, 1'b0);
        chk_addr_at(16, 15, 1'b1);
        chk_addr_at(17, 15, 1'b0);
        wait_cyc(18); chk("lit_rgb_last", {vga_r, vga_g, vga_b}, 12'hAB3);
        wait_cyc(19); chk("lit_rgb_gated", {vga_r, vga_g, vga_b}, 12'h000);
        wait_cyc(46); chk("lit_hs_before", vga_hs, 1'b1);
        wait_cyc(47); chk("lit_hs_fall", vga_hs, 1'b0);
        wait_cyc(52); chk("lit_hs_low", vga_hs, 1'b0);
        wait_cyc(53); chk("lit_hs_rise", vga_hs, 1'b1);
        chk_addr_at(57, 16, 1'b1);
        wait_cyc(300); mode = 2'b01;
        chk_addr_at(520, 159, 1'b1);
        chk_addr_at(561, 159, 1'b0);
        wait_cyc(1458); chk("lit_vs_before", vga_vs, 1'b1);
        wait_cyc(1459); chk("lit_vs_fall", vga_vs, 1'b0);

        // frame 2, mode 01
        chk_addr_at(FRAME + 1, 0, 1'b1);
        chk_addr_at(FRAME + 2, 0, 1'b1);
        chk_addr_at(FRAME + 3, 1, 1'b1);
        wait_cyc(FRAME + 3); chk("lit_fs_frame2", frame_start, 1'b1);
        chk_addr_at(FRAME + 32, 15, 1'b1);
        chk_addr_at(FRAME + 33, 15, 1'b0);
        chk_addr_at(FRAME + 57, 0, 1'b1);
        chk_addr_at(FRAME + 113, 16, 1'b1);
        wait_cyc(FRAME + 300); mode = 2'b10;
        chk_addr_at(FRAME + 19 * HT + 32, 159, 1'b1);
        chk_addr_at(FRAME + 20 * HT + 1, 159, 1'b0);

        // frame 3, mode 10
        chk_addr_at(2 * FRAME + 1, 15, 1'b1);
        chk_addr_at(2 * FRAME + 16, 0, 1'b1);
        chk_addr_at(2 * FRAME + 17, 0, 1'b0);
        chk_addr_at(2 * FRAME + HT + 1, 31, 1'b1);
        chk_addr_at(2 * FRAME + HT + 16, 16, 1'b1);
        wait_cyc(2 * FRAME + 300); mode = 2'b11;

        // frame 4, mode 11, then asynchronous reset mid-line
        chk_addr_at(3 * FRAME + 1, 15, 1'b1);
        chk_addr_at(3 * FRAME + 2, 15, 1'b1);
        chk_addr_at(3 * FRAME + 3, 14, 1'b1);
        wait_cyc(3 * FRAME + 280); mode = 2'b00;
        chk_addr_at(3 * FRAME + 300, 38, 1'b1);
        #5 rst = 1'b1;
        #1;
        chk("rst_addr", fb.addr, 0);
        chk("rst_rd_en", fb.rd_en, 1'b0);
        chk("rst_hs", vga_hs, 1'b1);
        chk("rst_vs", vga_vs, 1'b1);
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        chk("rst_fs", frame_start, 1'b0);
        repeat (2) @(negedge clk_25mHz);
        #1 rst = 1'b0;
        chk_addr_at(1, 0, 1'b1);
        chk_addr_at(2, 1, 1'b1);
        wait_cyc(3); chk("post_rst_fs", frame_start, 1'b1);
        chk_addr_at(FRAME + 1, 0, 1'b1);
        wait_cyc(FRAME + 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_fb_scan.md
# vga_fb_scan

Parametrised VGA scan-out engine that generates display timing, produces framebuffer read addresses and drives 4-bit-per-channel VGA pins from returned pixel data. It replaces the fixed 1:1 address counter plus separate timing controller arrangement. It adds 2x upscaling, horizontal mirroring, configurable memory read latency and pipeline-aligned syncs. It sits between the block-RAM framebuffer and the board VGA connector in the 25 MHz pixel domain.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48: horizontal porch and sync widths
- V_ACTIVE, 480: visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33: vertical porch and sync widths
- FB_W / FB_H, 320 / 240: framebuffer width and height in pixels; must satisfy 2*FB_W ≤ H_ACTIVE and 2*FB_H ≤ V_ACTIVE
- ADDR_W, 17: address width; must satisfy 2^ADDR_W ≥ FB_W*FB_H
- MEM_LAT, 1: cycles from addr to valid data_in (≥1)
- clk_25mHz  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- mode  in  2  bit0 = 2x upscale, bit1 = horizontal mirror
- data_in  in  12  pixel {R[11:8],G[7:4],B[3:0]}
- addr  out  ADDR_W  framebuffer read address (registered)
- rd_en  out  1  addr is valid this cycle
- vga_hs / vga_vs  out  1 each  active-low syncs
- vga_r / vga_g / vga_b  out  4 each  colour outputs
- frame_start  out  1  one-cycle pulse when counters are at h=0, v=0

## Operation
- Raw counters h (0..H_total-1) and v (0..V_total-1) advance every clock. H_total = H_ACTIVE+H_FP+H_SYNC+H_BP; V_total is defined the same way.
- mode is latched into mode_q only when h=0 and v=0. Changes mid-frame take effect at the next frame.
- Scale S = 1 if mode_q[0]=0, else 2. The displayed region is h < S*FB_W and v < S*FB_H, anchored at the top-left. Outside this region, rd_en=0 and RGB is forced to 0.
- Addresses come from counters; no multiplier is used.
  - row_base starts at 0 each frame.
  - row_base increases by FB_W at the end of each displayed line when S=1, and at the end of every second displayed line when S=2.
  - The column index advances every pixel when S=1 and every second pixel when S=2.
  - addr = row_base + col. In mirror mode, col counts down from FB_W-1 to 0 instead of up.
- When rd_en=0, addr holds its last value. addr returns to 0 at frame start.
- The maximum address issued is FB_W*FB_H-1. No address beyond it is ever issued.
- RGB output is the registered data_in, gated by the region flag delayed by MEM_LAT+1.
- Reset (asynchronous, mid-operation allowed): h=v=0, row_base=0, addr=0, rd_en=0, vga_hs=vga_vs=1, RGB=0, frame_start=0, mode_q=00. On release, scanning restarts at h=0, v=0.

## Timing
- addr/rd_en for counter position (h,v) are registered: they are valid 1 cycle after the counters reach (h,v).
- data_in is sampled MEM_LAT cycles after addr.
- RGB is registered, so it appears MEM_LAT+2 cycles after the counter position.
- vga_hs, vga_vs and frame_start are delayed through a MEM_LAT+2 shift register, so they align with RGB.
- With defaults, vga_hs is low for 96 cycles on raw h=656..751, and vga_vs is low on raw v=490..491. Both are shifted by 3 cycles at the pins.
- With defaults, one frame = 800*525 = 420000 cycles.

## Configuration
- VGA_FB_TESTPAT_EN defined:
  - data_in is ignored.
  - The pixel source is 8 vertical colour bars, each FB_W/8 framebuffer columns wide, in the order white, yellow, cyan, green, magenta, red, blue, black.
  - Bars follow the scaled and mirrored column index.
  - addr, rd_en and timing are unchanged.
- Not defined: pixels come from data_in only.

## Test plan
- Reset, mode=00, defaults. Required:
  - Line 0 issues addr 0..319 with rd_en=1.
  - Line 1 starts at 320.
  - Line 239 ends at 76799.
  - Lines 240..524 have rd_en=0.
- mode=01. Required:
  - Line 0 issues 0,0,1,1,…,319,319.
  - Line 1 repeats 0..319 doubled.
  - Line 2 starts at 320.
  - Line 479 ends at 76799.
- mode=10. Required: line 0 issues 319 down to 0, and line 1 issues 639 down to 320.
- data_in=12'hABC, MEM_LAT=1. Required:
  - vga_r=A, vga_g=B, vga_b=C exactly 3 cycles after the first active counter position.
  - RGB is 0 at raw h≥320.
  - vga_hs falls 3 cycles after h=656 and stays low 96 cycles.
- Drive mode 00→01 on line 100. Required:
  - The current frame continues 1x through addr 76799.
  - The next frame_start pulse occurs, then 2x addressing follows.
- Assert rst on line 50. Required:
  - All outputs take their reset values without waiting for a clock.
  - After release, addr 0 is issued 1 cycle after the counters restart.
